// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg
//   Shared types and default widths for the DataRam arbiter.
//   ARB_ADDR_W / ARB_DATA_W : default address / data widths.
//   arb_state_t             : arbiter FSM encoding.
//   mem_req_t               : command latched from the winning port.
//                             Sized from the package widths, so a
//                             top-level width override must change
//                             these defaults as well.
package data_mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 8;
    localparam int unsigned ARB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
//   Combinational two-way request picker.
//   req_i[1:0]   : per-port request.
//   last_owner_i : port served by the previous access.
//   winner_o     : selected port (only meaningful when |req_i).
//   conflict_o   : both ports requesting in this cycle.
//   FIXED_PRI    : 1 = port 0 wins every tie, 0 = alternate on ties.
module arb_rr2 #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       winner_o,
    output logic       conflict_o
);

    always_comb begin
        conflict_o = &req_i;
        winner_o   = 1'b0;
        case (req_i)
            2'b10:   winner_o = 1'b1;
            // On a tie round-robin hands the slot to whoever did not go last.
            2'b11:   winner_o = FIXED_PRI ? 1'b0 : ~last_owner_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port DataRam between the load/store unit (port 0)
//   and the loader/debug port (port 1). Every access runs
//   IDLE -> ACCESS -> (RESP for reads) -> IDLE.
//   CLK, Reset            : clock, synchronous active-high reset.
//   req, we               : per-port request / write enable (bit = port).
//   addr0/1, wdata0/1     : per-port address and write data.
//   gnt                   : one-cycle pulse while the port's access is issued.
//   rvalid, rdata         : one-cycle read-return pulse and shared read data.
//   conflict_cnt          : saturating count of sampled ties.
//   MemRead, MemWrite     : DataRam strobes, forced low while Reset is high.
//   DataSrcA, DataSrcB    : DataRam address / write data.
//   DataMemOut            : DataRam read data, valid the cycle after MemRead.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ARB_ADDR_W,
    parameter int unsigned DATA_W    = ARB_DATA_W,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        conflict_cnt,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] DataSrcA,
    output logic [DATA_W-1:0] DataSrcB,
    input  logic [DATA_W-1:0] DataMemOut
);

    arb_state_t        state_q, state_d;
    mem_req_t          cmd_q, cmd_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              winner;
    logic              conflict;

    arb_rr2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .winner_o     (winner),
        .conflict_o   (conflict)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any latched command and pending rvalid.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cmd_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            cmd_q        <= cmd_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rvalid_d     = '0;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = ACCESS;
                    owner_d     = winner;
                    cmd_d.we    = winner ? we[1] : we[0];
                    cmd_d.addr  = winner ? addr1 : addr0;
                    cmd_d.wdata = winner ? wdata1 : wdata0;
                    if (conflict && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ACCESS: begin
                last_owner_d = owner_q;
                state_d      = cmd_q.we ? IDLE : RESP;
            end
            RESP: begin
                state_d           = IDLE;
                rdata_d           = DataMemOut;
                rvalid_d[owner_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        gnt      = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        DataSrcA = '0;
        DataSrcB = '0;
        if (state_q == ACCESS) begin
            gnt[owner_q] = 1'b1;
            DataSrcA     = cmd_q.addr;
            DataSrcB     = cmd_q.wdata;
            MemWrite     = cmd_q.we & ~Reset;
            MemRead      = ~cmd_q.we & ~Reset;
        end
    end

    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port DataRam between two requesters:
  - port 0: core load/store unit.
  - port 1: memory loader/debug port.
- Sits between the requesters and DataRam.
- Sequences every access through a small FSM and drives DataRam's MemRead, MemWrite, DataSrcA (address) and DataSrcB (write data).
- Returns read data with a valid pulse to the requester that issued the read.

Parameters:
- ADDR_W, 8, address width (DataSrcA width).
- DATA_W, 8, data width (DataSrcB / DataMemOut width).
- FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  2  per-port request; held until gnt.
- we  in  2  per-port write enable (1 = write, 0 = read); stable while req.
- addr0, addr1  in  ADDR_W  per-port address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- gnt  out  2  one-hot, one-cycle pulse: access issued for that port.
- rvalid  out  2  one-hot, one-cycle pulse: rdata holds that port's read result.
- rdata  out  DATA_W  registered read data, shared by both ports.
- conflict_cnt  out  8  saturating count of cycles in which a request was sampled with both req bits high.
- MemRead  out  1  to DataRam.
- MemWrite  out  1  to DataRam.
- DataSrcA  out  ADDR_W  to DataRam, address.
- DataSrcB  out  DATA_W  to DataRam, write data.
- DataMemOut  in  DATA_W  from DataRam; valid the cycle after MemRead is high.

Behaviour:
- Reset (sampled at a rising CLK edge):
  - state = IDLE; last_owner = 1, so port 0 wins the first tie.
  - gnt = 0, rvalid = 0, rdata = 0, conflict_cnt = 0.
  - MemRead = MemWrite = 0; DataSrcA = DataSrcB = 0.
- MemRead and MemWrite are gated by !Reset: no DataRam write commits in any cycle where Reset is high, including a reset arriving mid-access.
- IDLE:
  - If any req bit is high at the edge, pick owner and latch owner, we, addr and wdata of the winner. Next state is ACCESS.
  - Otherwise remain in IDLE.
- Arbitration with one req high: that port wins.
- Arbitration with both high:
  - FIXED_PRI = 1: port 0 wins.
  - FIXED_PRI = 0: the port that is not last_owner wins.
  - In both modes conflict_cnt increments, saturating at 255.
- ACCESS (exactly one cycle):
  - Drive DataSrcA = latched addr and DataSrcB = latched wdata.
  - MemWrite = latched we; MemRead = !latched we.
  - gnt[owner] = 1. The requester may drop or change req in the cycle after gnt.
  - last_owner <= owner.
  - Next state is RESP for a read, IDLE for a write.
- RESP (exactly one cycle):
  - MemRead = MemWrite = 0.
  - At the edge: rdata <= DataMemOut, rvalid[owner] <= 1 for one cycle. Next state is IDLE.
- Latency:
  - Read: req sampled at edge E0; gnt and MemRead during E0..E1; rvalid and rdata during E2..E3.
  - Write: memory updated at edge E1; port busy for 2 cycles.
- Back-to-back:
  - The IDLE cycle that carries rvalid may also sample the next request.
  - Maximum throughput is 1 read per 3 cycles and 1 write per 2 cycles.
- A losing port keeps req asserted and is served next. Round-robin guarantees service within one foreign access.
- Req dropped before gnt: legal only in IDLE before sampling. Once latched, the access completes even if req falls.
- Reset mid-operation: any state returns to IDLE; a pending rvalid is suppressed; the latched request is discarded.
- Address and data pass through unmodified; no width conversion.

Decomposition:
- Package data_mem_arb_pkg contains:
  - ADDR_W and DATA_W defaults.
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t.
  - typedef struct {we, addr, wdata} mem_req_t for the latched command.
- Sub-module arb_rr2: combinational 2-way picker.
  - Inputs: req[1:0], last_owner, FIXED_PRI.
  - Outputs: winner and conflict.
  - Instantiated once.

Test Plan:
- Reset with req = 2'b11 held → all outputs 0; no gnt and no MemWrite until the first edge after Reset falls.
- Port 0 write, addr 0x03, wdata 0xA5, then port 0 read of 0x03:
  - gnt[0] pulses each time; MemWrite high for exactly 1 cycle.
  - rvalid[0] arrives 2 cycles after the read gnt with rdata = 0xA5.
- Port 1 read of addr 0x01 (preloaded 0x3C) → rvalid[1] = 1, rdata = 0x3C, rvalid[0] stays 0.
- FIXED_PRI = 0, both ports request reads (addr0 = 0x00, addr1 = 0x02), held:
  - Grant order is 0, 1, 0.
  - conflict_cnt increments on each tie and reaches 255, then holds.
- FIXED_PRI = 1 under the same stimulus → port 0 always granted; port 1 granted only after req[0] drops.
- Assert Reset during ACCESS of a port 1 write of 0xFF to addr 0x05:
  - MemWrite gated low; mem[0x05] unchanged; state is IDLE next cycle; no rvalid.
